// File: rtl/hms_pkg.sv
// Shared types and default limits for the hms_time_counter block.
// Field-select codes, RUN/HOLD states and default wrap limits.
package hms_pkg;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_HR   = 2'd2,
    SEL_RSVD = 2'd3
  } sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int DEF_W         = 8;
  localparam int DEF_SEC_LIMIT = 59;
  localparam int DEF_MIN_LIMIT = 59;
  localparam int DEF_HR_LIMIT  = 23;

endpackage

// File: rtl/wrap_field_counter.sv
// One time field: modulo-(LIMIT+1) counter with saturating load.
// wrap is a same-cycle carry out, only produced by inc, never by load.
module wrap_field_counter
  import hms_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LIMIT = DEF_SEC_LIMIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] sat_val;
  logic         at_lim;

  assign sat_val = (load_val > LIM) ? LIM : load_val;
  assign at_lim  = (value == LIM);
  assign wrap    = inc && at_lim;

  // Field register: reset, then load, then wrapping increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= sat_val;
    end else if (inc) begin
      value <= at_lim ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/hms_time_counter.sv
// Cascaded h:m:s counter with RUN/HOLD set mode and 12h view.
// Optional alarm comparator enabled by defining HMS_ALARM_EN.
module hms_time_counter
  import hms_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int SEC_LIMIT = DEF_SEC_LIMIT,
  parameter int MIN_LIMIT = DEF_MIN_LIMIT,
  parameter int HR_LIMIT  = DEF_HR_LIMIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         hold,
  input  logic         set_valid,
  output logic         set_ready,
  input  logic [1:0]   set_sel,
  input  logic [W-1:0] set_value,
  input  logic         mode_12h,
`ifdef HMS_ALARM_EN
  input  logic         alarm_arm,
  input  logic [W-1:0] alarm_hr,
  input  logic [W-1:0] alarm_min,
  output logic         alarm,
`endif
  output logic [W-1:0] seconds,
  output logic [W-1:0] minutes,
  output logic [W-1:0] hours,
  output logic         pm,
  output logic         day_carry,
  output logic         running
);

  localparam bit TWELVE_OK = (HR_LIMIT == 23);

  state_e       state;
  state_e       state_nx;
  logic         accept;
  logic         inc_sec;
  logic         ld_sec;
  logic         ld_min;
  logic         ld_hr;
  logic         sec_wrap;
  logic         min_wrap;
  logic         hr_wrap;
  logic [W-1:0] hr_int;

  assign accept  = set_valid && set_ready;
  assign inc_sec = tick && (state == ST_RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nx;
  end

  // Next state: hold level selects HOLD, from either state.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RUN:  if (hold)  state_nx = ST_HOLD;
      ST_HOLD: if (!hold) state_nx = ST_RUN;
      default: state_nx = ST_RUN;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    running   = (state == ST_RUN);
    set_ready = (state == ST_HOLD);
  end

  // Route an accepted load to the selected field.
  always_comb begin
    ld_sec = 1'b0;
    ld_min = 1'b0;
    ld_hr  = 1'b0;
    if (accept) begin
      unique case (sel_e'(set_sel))
        SEL_SEC:  ld_sec = 1'b1;
        SEL_MIN:  ld_min = 1'b1;
        SEL_HR:   ld_hr  = 1'b1;
        SEL_RSVD: ;
        default:  ;
      endcase
    end
  end

  wrap_field_counter #(.W(W), .LIMIT(SEC_LIMIT)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (inc_sec),
    .load     (ld_sec),
    .load_val (set_value),
    .value    (seconds),
    .wrap     (sec_wrap)
  );

  wrap_field_counter #(.W(W), .LIMIT(MIN_LIMIT)) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (sec_wrap),
    .load     (ld_min),
    .load_val (set_value),
    .value    (minutes),
    .wrap     (min_wrap)
  );

  wrap_field_counter #(.W(W), .LIMIT(HR_LIMIT)) u_hr (
    .clk      (clk),
    .rst      (rst),
    .inc      (min_wrap),
    .load     (ld_hr),
    .load_val (set_value),
    .value    (hr_int),
    .wrap     (hr_wrap)
  );

  // Day rollover pulse, one cycle after the hours field wraps.
  always_ff @(posedge clk) begin
    if (rst) day_carry <= 1'b0;
    else     day_carry <= hr_wrap;
  end

  // 12h presentation of the internal 24h hour count.
  always_comb begin
    hours = hr_int;
    pm    = 1'b0;
    if (TWELVE_OK && mode_12h) begin
      if (hr_int == '0) begin
        hours = W'(12);
      end else if (hr_int >= W'(12)) begin
        pm = 1'b1;
        if (hr_int != W'(12)) hours = hr_int - W'(12);
      end
    end
  end

`ifdef HMS_ALARM_EN
  logic tick_d;

  // Remember that the last edge advanced the time by a tick.
  always_ff @(posedge clk) begin
    if (rst) tick_d <= 1'b0;
    else     tick_d <= inc_sec;
  end

  // Alarm matches only on tick-driven arrival at hh:mm:00.
  always_comb begin
    alarm = tick_d && alarm_arm
         && (seconds == '0)
         && (minutes == alarm_min)
         && (hr_int == alarm_hr);
  end
`endif

endmodule

// File: tb/tb_hms_time_counter.sv
// Vector-table bench for hms_time_counter with an expectation queue.
// Alarm sequence runs only when HMS_ALARM_EN is defined.
module tb_hms_time_counter;

  typedef struct packed {
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hr;
    logic       pm;
    logic       carry;
    logic       run;
    logic       rdy;
  } exp_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       tick;
    logic       hold;
    logic       sv;
    logic [1:0] sel;
    logic [7:0] val;
    logic       mode;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       hold = 1'b0;
  logic       set_valid = 1'b0;
  logic       set_ready;
  logic [1:0] set_sel = 2'd0;
  logic [7:0] set_value = 8'd0;
  logic       mode_12h = 1'b0;
  logic [7:0] seconds;
  logic [7:0] minutes;
  logic [7:0] hours;
  logic       pm;
  logic       day_carry;
  logic       running;
`ifdef HMS_ALARM_EN
  logic       alarm_arm = 1'b0;
  logic [7:0] alarm_hr = 8'd0;
  logic [7:0] alarm_min = 8'd0;
  logic       alarm;
`endif

  int   checks = 0;
  int   fails = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  hms_time_counter dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .hold      (hold),
    .set_valid (set_valid),
    .set_ready (set_ready),
    .set_sel   (set_sel),
    .set_value (set_value),
    .mode_12h  (mode_12h),
`ifdef HMS_ALARM_EN
    .alarm_arm (alarm_arm),
    .alarm_hr  (alarm_hr),
    .alarm_min (alarm_min),
    .alarm     (alarm),
`endif
    .seconds   (seconds),
    .minutes   (minutes),
    .hours     (hours),
    .pm        (pm),
    .day_carry (day_carry),
    .running   (running)
  );

  function automatic vec_t mk(
    input string n,
    input logic r, input logic t, input logic h,
    input logic s, input int sl, input int vl,
    input logic md,
    input int es, input int em, input int eh,
    input logic ep, input logic ec,
    input logic er, input logic ey
  );
    vec_t v;
    v.name    = n;
    v.rst     = r;
    v.tick    = t;
    v.hold    = h;
    v.sv      = s;
    v.sel     = 2'(sl);
    v.val     = 8'(vl);
    v.mode    = md;
    v.e.sec   = 8'(es);
    v.e.min   = 8'(em);
    v.e.hr    = 8'(eh);
    v.e.pm    = ep;
    v.e.carry = ec;
    v.e.run   = er;
    v.e.rdy   = ey;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    exp_t got;
    exp_t e;
    rst       = v.rst;
    tick      = v.tick;
    hold      = v.hold;
    set_valid = v.sv;
    set_sel   = v.sel;
    set_value = v.val;
    mode_12h  = v.mode;
    exp_q.push_back(v.e);
    @(posedge clk);
    #1;
    got = '{seconds, minutes, hours, pm,
            day_carry, running, set_ready};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      fails++;
      $display("FAIL %s got %0d:%0d:%0d pm=%b c=%b run=%b rdy=%b exp %0d:%0d:%0d pm=%b c=%b run=%b rdy=%b",
        v.name, got.sec, got.min, got.hr, got.pm, got.carry,
        got.run, got.rdy, e.sec, e.min, e.hr, e.pm, e.carry,
        e.run, e.rdy);
    end
  endtask

`ifdef HMS_ALARM_EN
  task automatic chk_alarm(input string n, input logic e);
    checks++;
    if (alarm !== e) begin
      fails++;
      $display("FAIL %s alarm got %b exp %b", n, alarm, e);
    end
  endtask
`endif

  initial begin
    // reset
    tbl.push_back(mk("rst0", 1,0,0,0,0,0,0, 0,0,0,0,0,1,0));
    tbl.push_back(mk("rst1", 1,1,0,1,0,9,0, 0,0,0,0,0,1,0));
    // 60 ticks: seconds count up then wrap into minutes
    for (int i = 0; i < 60; i++)
      tbl.push_back(mk($sformatf("tick%0d", i),
        0,1,0,0,0,0,0, (i + 1) % 60, (i == 59) ? 1 : 0, 0,
        0,0,1,0));
    // load 23:59:58 in HOLD, release, two ticks
    tbl.push_back(mk("hold_in", 0,0,1,0,0,0,0, 0,1,0,0,0,0,1));
    tbl.push_back(mk("ld_hr23", 0,0,1,1,2,23,0, 0,1,23,0,0,0,1));
    tbl.push_back(mk("ld_mn59", 0,0,1,1,1,59,0, 0,59,23,0,0,0,1));
    tbl.push_back(mk("ld_sc58", 0,0,1,1,0,58,0, 58,59,23,0,0,0,1));
    tbl.push_back(mk("hold_tk", 0,1,1,0,0,0,0, 58,59,23,0,0,0,1));
    tbl.push_back(mk("release", 0,0,0,0,0,0,0, 58,59,23,0,0,1,0));
    tbl.push_back(mk("tk_59",   0,1,0,0,0,0,0, 59,59,23,0,0,1,0));
    tbl.push_back(mk("tk_wrap", 0,1,0,0,0,0,0, 0,0,0,0,1,1,0));
    tbl.push_back(mk("carry_0", 0,0,0,0,0,0,0, 0,0,0,0,0,1,0));
    // hold with coincident tick: tick still applied
    tbl.push_back(mk("hold_tk1", 0,1,1,0,0,0,0, 1,0,0,0,0,0,1));
    tbl.push_back(mk("sat_75",  0,0,1,1,0,75,0, 59,0,0,0,0,0,1));
    tbl.push_back(mk("rsvd",    0,0,1,1,3,5,0, 59,0,0,0,0,0,1));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk($sformatf("htick%0d", i),
        0,1,1,0,0,0,0, 59,0,0,0,0,0,1));
    // 12h presentation
    tbl.push_back(mk("h12_12",  0,0,1,1,2,12,1, 59,0,12,1,0,0,1));
    tbl.push_back(mk("h12_13",  0,0,1,1,2,13,1, 59,0,1,1,0,0,1));
    tbl.push_back(mk("h24_13",  0,0,1,0,0,0,0, 59,0,13,0,0,0,1));
    tbl.push_back(mk("h12_0",   0,0,1,1,2,0,1, 59,0,12,0,0,0,1));
    tbl.push_back(mk("sat_hr",  0,0,1,1,2,99,0, 59,0,23,0,0,0,1));
    // load on the releasing cycle is accepted
    tbl.push_back(mk("ld_rel",  0,0,0,1,1,7,0, 59,7,23,0,0,1,0));
    tbl.push_back(mk("tk_min",  0,1,0,0,0,0,0, 0,8,23,0,0,1,0));
    tbl.push_back(mk("hold2",   0,0,1,0,0,0,0, 0,8,23,0,0,0,1));
    // reset mid-load discards the load
    tbl.push_back(mk("rst_ld",  1,0,1,1,0,30,0, 0,0,0,0,0,1,0));
    tbl.push_back(mk("post_rst",0,0,0,0,0,0,0, 0,0,0,0,0,1,0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);

`ifdef HMS_ALARM_EN
    alarm_arm = 1'b1;
    alarm_hr  = 8'd7;
    alarm_min = 8'd30;
    apply(mk("a_hold", 0,0,1,0,0,0,0, 0,0,0,0,0,0,1));
    apply(mk("a_ldh",  0,0,1,1,2,7,0, 0,0,7,0,0,0,1));
    apply(mk("a_ldm",  0,0,1,1,1,29,0, 0,29,7,0,0,0,1));
    apply(mk("a_lds",  0,0,1,1,0,59,0, 59,29,7,0,0,0,1));
    chk_alarm("a_noload", 1'b0);
    apply(mk("a_rel",  0,0,0,0,0,0,0, 59,29,7,0,0,1,0));
    apply(mk("a_tick", 0,1,0,0,0,0,0, 0,30,7,0,0,1,0));
    chk_alarm("a_fire", 1'b1);
    apply(mk("a_idle", 0,0,0,0,0,0,0, 0,30,7,0,0,1,0));
    chk_alarm("a_pulse", 1'b0);
    apply(mk("d_hold", 0,0,1,0,0,0,0, 0,30,7,0,0,0,1));
    apply(mk("d_ldm",  0,0,1,1,1,29,0, 0,29,7,0,0,0,1));
    apply(mk("d_lds",  0,0,1,1,0,59,0, 59,29,7,0,0,0,1));
    alarm_arm = 1'b0;
    apply(mk("d_rel",  0,0,0,0,0,0,0, 59,29,7,0,0,1,0));
    apply(mk("d_tick", 0,1,0,0,0,0,0, 0,30,7,0,0,1,0));
    chk_alarm("a_disarm", 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule
